// File: rtl/dlfloat16_addsub_arb.sv
// Round-robin arbiter feeding one shared DLFloat16 add/sub datapath.
// Define DLF_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module dlfloat16_sub (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);
    logic              a_zero;
    logic              b_zero;
    logic              a_spec;
    logic              b_spec;
    logic              swap;
    logic              sgn_big;
    logic              eff_sub;
    logic [14:0]       big;
    logic [14:0]       sml;
    logic [5:0]        d;
    logic [4:0]        dd;
    logic [12:0]       big_sig;
    logic [12:0]       sml_sig;
    logic [26:0]       wide;
    logic [12:0]       sml_sh;
    logic [13:0]       sum;
    logic [3:0]        lz;
    logic [12:0]       norm;
    logic signed [7:0] exp_n;
    logic signed [7:0] exp_r;
    logic              up;
    logic [9:0]        man_r;

    always_comb begin
        a_zero  = a[14:9] == 6'd0;
        b_zero  = b[14:9] == 6'd0;
        a_spec  = a[14:0] == 15'h7FFF;
        b_spec  = b[14:0] == 15'h7FFF;
        swap    = b[14:0] > a[14:0];
        big     = swap ? b[14:0] : a[14:0];
        sml     = swap ? a[14:0] : b[14:0];
        // a - b: the magnitude winner carries the sign, b's sign inverted
        sgn_big = swap ? ~b[15] : a[15];
        eff_sub = a[15] == b[15];
        d       = big[14:9] - sml[14:9];
        dd      = (d > 6'd14) ? 5'd14 : d[4:0];
        big_sig = {1'b1, big[8:0], 3'b000};
        sml_sig = {1'b1, sml[8:0], 3'b000};
        wide    = {sml_sig, 14'd0} >> dd;
        sml_sh  = wide[26:14] | {12'd0, |wide[13:0]};
        if (eff_sub)
            sum = {1'b0, big_sig} - {1'b0, sml_sh};
        else
            sum = {1'b0, big_sig} + {1'b0, sml_sh};
        lz = 4'd0;
        for (int i = 0; i <= 12; i++)
            if (sum[i]) lz = 4'(12 - i);
        if (sum[13]) begin
            norm  = {sum[13:2], |sum[1:0]};
            exp_n = $signed({2'b00, big[14:9]}) + 8'sd1;
        end else begin
            norm  = sum[12:0] << lz;
            exp_n = $signed({2'b00, big[14:9]}) - $signed({4'b0000, lz});
        end
        up    = norm[2] & (norm[3] | norm[1] | norm[0]);
        man_r = {1'b0, norm[11:3]} + {9'd0, up};
        exp_r = man_r[9] ? exp_n + 8'sd1 : exp_n;
        if (a_spec || b_spec)
            y = 16'hFFFF;
        else if (a_zero && b_zero)
            y = 16'h0000;
        else if (b_zero)
            y = a;
        else if (a_zero)
            y = {~b[15], b[14:0]};
        else if (sum == 14'd0)
            y = 16'h0000;
        else if (exp_r < 8'sd1)
            y = 16'h0000;
        else if (exp_r > 8'sd63 ||
                 (exp_r == 8'sd63 && man_r[8:0] == 9'h1FF))
            y = 16'hFFFF;
        else
            y = {sgn_big, exp_r[5:0], man_r[8:0]};
    end
endmodule

module dlfloat16_addsub_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [16*NREQ-1:0]   req_a,
    input  logic [16*NREQ-1:0]   req_b,
    input  logic [NREQ-1:0]      req_op,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [15:0]          resp_data,
    output logic [IDW-1:0]       resp_id
);
    logic            s1_valid;
    logic [15:0]     s1_a;
    logic [15:0]     s1_b;
    logic [IDW-1:0]  s1_id;
    logic            out_free;
    logic            s1_adv;
    logic            s1_free;
    logic            grant_any;
    logic            take;
    logic [IDW-1:0]  grant;
    logic [IDW-1:0]  idx;
    logic [15:0]     sel_a;
    logic [15:0]     sel_b;
    logic [15:0]     sel_b_eff;
    logic            sel_op;
    logic [15:0]     sub_y;
`ifndef DLF_ARB_FIXED_PRIO_EN
    logic [IDW-1:0]  last_grant;
`endif

    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        idx       = '0;
`ifdef DLF_ARB_FIXED_PRIO_EN
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = IDW'(i);
            if (req_valid[idx]) begin
                grant     = idx;
                grant_any = 1'b1;
            end
        end
`else
        for (int i = 0; i < NREQ; i++) begin
            idx = IDW'((int'(last_grant) + 1 + i) % NREQ);
            if (!grant_any && req_valid[idx]) begin
                grant     = idx;
                grant_any = 1'b1;
            end
        end
`endif
    end

    assign out_free = !resp_valid || resp_ready;
    assign s1_adv   = s1_valid && out_free;
    assign s1_free  = !s1_valid || s1_adv;
    assign take     = grant_any && s1_free && !rst;

    always_comb begin
        req_ready = '0;
        if (take) req_ready[grant] = 1'b1;
    end

    // Zero and the all-ones value keep their sign for the special checks
    assign sel_a  = req_a[{grant, 4'b0000} +: 16];
    assign sel_b  = req_b[{grant, 4'b0000} +: 16];
    assign sel_op = req_op[grant];
    assign sel_b_eff = (sel_op || sel_b == 16'h0000 || sel_b == 16'hFFFF)
                     ? sel_b : {~sel_b[15], sel_b[14:0]};

    dlfloat16_sub u_sub (
        .a (s1_a),
        .b (s1_b),
        .y (sub_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_id      <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_id    <= '0;
        end else begin
            if (s1_free) begin
                s1_valid <= take;
                if (take) begin
                    s1_a  <= sel_a;
                    s1_b  <= sel_b_eff;
                    s1_id <= grant;
                end
            end
            if (s1_adv) begin
                resp_valid <= 1'b1;
                resp_data  <= sub_y;
                resp_id    <= s1_id;
            end else if (resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

`ifndef DLF_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_grant <= IDW'(NREQ - 1);
        else if (take)
            last_grant <= grant;
    end
`endif
endmodule

// File: tb/tb_dlfloat16_addsub_arb.sv
// Bench for dlfloat16_addsub_arb: directed and random steps checked
// against a real-arithmetic DLFloat16 model and a transaction queue.
module tb_dlfloat16_addsub_arb;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [16*NREQ-1:0]  req_a;
    logic [16*NREQ-1:0]  req_b;
    logic [NREQ-1:0]     req_op;
    logic                resp_valid;
    logic                resp_ready;
    logic [15:0]         resp_data;
    logic [IDW-1:0]      resp_id;

    dlfloat16_addsub_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IDW-1:0] id;
        logic [15:0]    data;
    } exp_t;

    exp_t        exp_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          m_last = NREQ - 1;
    bit          just_acc = 1'b0;
    logic [15:0] pop_data;
    logic [IDW-1:0] pop_id;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic real p2(input int k);
        real r = 1.0;
        if (k >= 0) repeat (k) r = r * 2.0;
        else repeat (-k) r = r / 2.0;
        return r;
    endfunction

    function automatic real dec(input logic [15:0] x);
        real mag;
        if (x[14:9] == 6'd0) return 0.0;
        mag = (1.0 + real'(int'(x[8:0])) / 512.0) * p2(int'(x[14:9]) - 31);
        return x[15] ? -mag : mag;
    endfunction

    function automatic logic [15:0] enc(input real r);
        logic s;
        real  f;
        real  fr;
        int   e;
        int   q;
        if (r == 0.0) return 16'h0000;
        s = r < 0.0;
        f = s ? -r : r;
        e = 31;
        while (f >= 2.0) begin f = f / 2.0; e++; end
        while (f < 1.0) begin f = f * 2.0; e--; end
        q  = $rtoi(f * 512.0);
        fr = f * 512.0 - real'(q);
        if (fr > 0.5 || (fr == 0.5 && q % 2 == 1)) q++;
        if (q == 1024) begin q = 512; e++; end
        if (e < 1) return 16'h0000;
        if (e > 63 || (e == 63 && q == 1023)) return 16'hFFFF;
        return {s, 6'(e), 9'(q - 512)};
    endfunction

    function automatic logic [15:0] ref_op(input logic [15:0] a,
                                           input logic [15:0] b,
                                           input logic op);
        if (a[14:0] == 15'h7FFF || b[14:0] == 15'h7FFF) return 16'hFFFF;
        return enc(op ? dec(a) - dec(b) : dec(a) + dec(b));
    endfunction

    function automatic int pick(input logic [NREQ-1:0] v);
`ifdef DLF_ARB_FIXED_PRIO_EN
        for (int i = NREQ - 1; i >= 0; i--) if (v[i]) pick = i;
`else
        pick = 0;
        for (int i = NREQ - 1; i >= 0; i--)
            if (v[(m_last + 1 + i) % NREQ]) pick = (m_last + 1 + i) % NREQ;
`endif
    endfunction

    function automatic logic [15:0] rand_num();
        return {1'($urandom), 6'($urandom_range(10, 50)), 9'($urandom)};
    endfunction

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_a[16*i +: 16] = rand_num();
            req_b[16*i +: 16] = ($urandom_range(0, 15) == 0)
                              ? 16'h0000 : rand_num();
            req_op[i] = 1'($urandom);
        end
    endtask

    task automatic set_op(input int i, input logic [15:0] a,
                          input logic [15:0] b, input logic op);
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
        req_op[i] = op;
    endtask

    // One cycle: drive, check against the model, advance the model
    task automatic step(input logic [NREQ-1:0] v, input logic rr);
        int g;
        logic [NREQ-1:0] expr;
        bit can;
        bit ev;
        req_valid  = v;
        resp_ready = rr;
        #1;
        can  = (exp_q.size() < 2) || rr;
        g    = pick(v);
        expr = '0;
        if (can && v != '0) expr[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(expr));
        ev = exp_q.size() >= 2 || (exp_q.size() == 1 && !just_acc);
        chk("resp_valid", 32'(resp_valid), 32'(ev));
        if (ev) begin
            chk("resp_data", 32'(resp_data), 32'(exp_q[0].data));
            chk("resp_id", 32'(resp_id), 32'(exp_q[0].id));
            if (rr) begin
                pop_data = resp_data;
                pop_id   = resp_id;
                void'(exp_q.pop_front());
            end
        end
        if (expr != '0) begin
            exp_q.push_back('{id: IDW'(g),
                              data: ref_op(req_a[16*g +: 16],
                                           req_b[16*g +: 16], req_op[g])});
            m_last   = g;
            just_acc = 1'b1;
        end else begin
            just_acc = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        req_valid  = '1;
        resp_ready = 1'b0;
        req_a      = '0;
        req_b      = '0;
        req_op     = '0;
        pop_data   = '0;
        pop_id     = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_resp_data", 32'(resp_data), 32'h0);
        chk("rst_resp_id", 32'(resp_id), 32'h0);
        rst = 1'b0;

        set_op(0, 16'h3E00, 16'h3E00, 1'b0);
        step(4'b0001, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        chk("add_data", 32'(pop_data), 32'h4000);
        chk("add_id", 32'(pop_id), 32'h0);

        set_op(2, 16'h4000, 16'h3E00, 1'b1);
        step(4'b0100, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        chk("sub_data", 32'(pop_data), 32'h3E00);
        chk("sub_id", 32'(pop_id), 32'h2);

        set_op(1, 16'hFFFF, 16'h3E00, 1'b0);
        step(4'b0010, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        chk("spec_ffff", 32'(pop_data), 32'hFFFF);

        set_op(3, 16'h0000, 16'h0000, 1'b0);
        step(4'b1000, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        chk("zero_zero", 32'(pop_data), 32'h0000);

        set_op(0, 16'h7FFE, 16'h7FFE, 1'b0);
        set_op(1, 16'h0201, 16'h0200, 1'b1);
        set_op(2, 16'h3E01, 16'h3E00, 1'b1);
        set_op(3, 16'hBE00, 16'h0000, 1'b1);
        for (int i = 0; i < 4; i++) step(4'b1111, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);

        for (int i = 0; i < 12; i++) begin
            rand_ops();
            step(4'b1111, 1'b1);
        end
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);

        rand_ops();
        for (int i = 0; i < 5; i++) step(4'b0111, 1'b0);
        step(4'b0111, 1'b1);
        for (int i = 0; i < 4; i++) step(4'b0000, 1'b1);

        for (int i = 0; i < 300; i++) begin
            rand_ops();
            step(NREQ'($urandom), $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 4; i++) step(4'b0000, 1'b1);

        rand_ops();
        step(4'b0110, 1'b0);
        step(4'b0110, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_resp_valid", 32'(resp_valid), 32'h0);
        chk("midrst_resp_data", 32'(resp_data), 32'h0);
        chk("midrst_req_ready", 32'(req_ready), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        m_last   = NREQ - 1;
        just_acc = 1'b0;
        rand_ops();
        step(4'b1111, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        chk("post_rst_id", 32'(pop_id), 32'h0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule

// File: doc/dlfloat16_addsub_arb.md
# dlfloat16_addsub_arb

Round-robin arbiter and pipeline controller that shares one combinational `dlfloat16_sub` datapath between `NREQ` requesters, each issuing DLFloat16 add or subtract operations.

- The block accepts one operation per cycle over valid/ready handshakes.
- It maps add onto the subtractor by conditioning the sign of b.
- Each result is returned through a registered, back-pressurable response port tagged with the requester id.
- It sits between the vector lanes' issue logic and the shared add/sub unit.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `IDW`, `$clog2(NREQ)`: width of the id tag.

Ports:
- `clk` in 1: single clock; all state on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `req_valid` in NREQ: per-requester operation valid.
- `req_ready` out NREQ: per-requester accept; at most one bit high.
- `req_a` in 16*NREQ: operand a, requester i at [16i+15:16i].
- `req_b` in 16*NREQ: operand b, same packing.
- `req_op` in NREQ: 0 = a+b, 1 = a−b.
- `resp_valid` out 1: result valid.
- `resp_ready` in 1: consumer accept.
- `resp_data` out 16: DLFloat16 result.
- `resp_id` out IDW: index of the requester that issued the result.

## Operation
- **Pipeline.** Two registered stages.
  - S1 holds `a`, `b_eff`, `id`, and a valid bit.
  - OUT holds `resp_data`, `resp_id`, and `resp_valid`.
  - `dlfloat16_sub` sits combinationally between S1 and OUT.
- **Operand conditioning**, done in the arbitration cycle before S1:
  - `b_eff = b` when op=1, when `b == 16'h0000`, or when `b == 16'hFFFF`.
  - Otherwise `b_eff = {~b[15], b[14:0]}`.
  - Zero and the all-ones special value are never sign-flipped, so the datapath's special-case checks remain intact.
- **Advance conditions.**
  - `out_free = !resp_valid | resp_ready`.
  - `s1_adv = s1_valid & out_free`.
  - `s1_free = !s1_valid | s1_adv`.
- **Arbitration.**
  - Round-robin over `req_valid`, starting at `(last_grant+1) mod NREQ`.
  - `req_ready[g]` is high only for the winner g, and only while `s1_free`.
  - `req_ready` depends combinationally on `req_valid`, `resp_valid`, and `resp_ready`; it has no dependence on the data inputs.
  - `last_grant` updates to g only on a completed handshake (`req_valid[g] & req_ready[g]`).
- **Stall.** With OUT full and `resp_ready` low, both S1 and OUT hold, and `req_ready` is all zero if S1 is full.
- **Reset.**
  - Outputs: `resp_valid`=0, `resp_data`=16'h0000, `resp_id`=0.
  - Internal state: `s1_valid`=0, `last_grant`=NREQ−1, so requester 0 has first priority.
  - `req_ready` is 0 during reset.
  - Reset mid-operation discards in-flight S1 and OUT contents with no response.
- **Order.** Responses leave in acceptance order; nothing is dropped or duplicated.

## Timing
- **Latency.** A handshake at edge k loads S1; OUT is loaded at edge k+1 if `out_free`. `resp_valid` is therefore high in the cycle after edge k+1 (2-cycle latency when unstalled).
- **Throughput.** One operation per cycle with `resp_ready` held high.
- **Response handshake.** `resp_valid` stays high, with `resp_data` and `resp_id` stable, until the edge where `resp_ready` is high.
- **Simultaneous events.** A response pop and a new S1→OUT transfer in the same cycle are allowed, so OUT stays full with the new entry.
- **Fairness.** A requester holding `req_valid` is granted within NREQ accepted handshakes.

## Configuration
- `DLF_ARB_FIXED_PRIO_EN` defined:
  - Fixed priority; the lowest asserted index always wins.
  - `last_grant` is not implemented.
- Undefined (default): round-robin as described above.
- All other behaviour is identical in both builds.

## Test plan
- **Single add.** Requester 0 sends a=16'h3E00, b=16'h3E00, op=0 (1.0+1.0).
  - `resp_data`=16'h4000, `resp_id`=0.
  - `resp_valid` rises 2 cycles after the handshake.
- **Single subtract.** Requester 2 sends a=16'h4000, b=16'h3E00, op=1 (2.0−1.0).
  - `resp_data`=16'h3E00, `resp_id`=2.
- **Special values.**
  - a=16'hFFFF, op=0 → `resp_data`=16'hFFFF.
  - a=16'h0000, b=16'h0000, op=0 → `resp_data`=16'h0000 (b not flipped).
- **Round-robin.** All 4 requesters hold `req_valid` continuously, with `resp_ready`=1.
  - Grant order is 0,1,2,3,0,…
  - `resp_id` sequence matches, one response per cycle.
  - With `DLF_ARB_FIXED_PRIO_EN` defined, the grant is always 0.
- **Backpressure.** Send 3 back-to-back requests, hold `resp_ready`=0 for 5 cycles, then release.
  - After 2 accepts, `req_ready` is all zero.
  - `resp_data` stays stable while stalled.
  - All 3 results arrive in order with no loss.
- **Reset mid-flight.** Assert `rst` with S1 and OUT full.
  - `resp_valid` goes to 0 asynchronously.
  - After release, the next request to be granted is requester 0.
